// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the iterative RV32M multiply/divide unit.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, Funct3, src_a, src_b, flush,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, Funct3, src_a, src_b, flush,
    output ready, busy, done, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unit: radix-2 shift-add multiply / restoring divide over XLEN cycles.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiply skip CALC.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam int unsigned     CntW   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
  logic [XLEN-1:0]   opnd_q, opnd_d, result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d, sign_a_q, sign_a_d, div_zero_q, div_zero_d;

  logic              a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag, quo, rem, final_res;
  logic [XLEN:0]     add_sum, rem_sh, rem_diff;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      sign_a_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      result_q   <= result_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      sign_a_q   <= sign_a_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Operand conditioning: MULHSU treats only rs1 as signed; DIVU/REMU/MULHU are unsigned.
  always_comb begin
    a_signed = (bus.Funct3 != 3'b011) && (!bus.Funct3[2] || !bus.Funct3[0]);
    b_signed = a_signed && (bus.Funct3 != 3'b010);
    sa       = a_signed && bus.src_a[XLEN-1];
    sb       = b_signed && bus.src_b[XLEN-1];
    a_mag    = sa ? -bus.src_a : bus.src_a;
    b_mag    = sb ? -bus.src_b : bus.src_b;
  end

  // One iteration; the divide remainder needs XLEN+1 bits after the left shift.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    rem_diff = rem_sh - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!rem_diff[XLEN]) acc_step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else if (acc_q[0]) begin
      acc_step = {add_sum, acc_q[XLEN-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  always_comb begin
    prod = neg_q ? -acc_step : acc_step;
    quo  = div_zero_q ? '1 : (neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0]);
    rem  = sign_a_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 final_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo;
      default:                final_res = rem;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    result_d   = result_q;
    op_d       = op_q;
    neg_d      = neg_q;
    sign_a_d   = sign_a_q;
    div_zero_d = div_zero_q;
    case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          op_d       = bus.Funct3;
          sign_a_d   = sa;
          neg_d      = sa ^ sb;
          div_zero_d = bus.Funct3[2] && (bus.src_b == '0);
          cnt_d      = '0;
          opnd_d     = bus.Funct3[2] ? b_mag : a_mag;
          acc_d      = {{XLEN{1'b0}}, (bus.Funct3[2] ? a_mag : b_mag)};
          state_d    = StCalc;
`ifdef MULDIV_EARLY_OUT_EN
          if (bus.Funct3[2] && (bus.src_b == '0)) begin
            result_d = bus.Funct3[1] ? bus.src_a : '1;
            state_d  = StDone;
          end else if (bus.Funct3[2] && !bus.Funct3[0] && (bus.src_a == MinNeg) &&
                       (bus.src_b == '1)) begin
            result_d = bus.Funct3[1] ? '0 : MinNeg;
            state_d  = StDone;
          end else if (!bus.Funct3[2] && ((bus.src_a == '0) || (bus.src_b == '0))) begin
            result_d = '0;
            state_d  = StDone;
          end
`endif
        end
      end
      StCalc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) begin
            result_d = final_res;
            state_d  = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.ready  = (state_q == StIdle);
    bus.busy   = (state_q == StCalc);
    bus.done   = (state_q == StDone);
    bus.result = result_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (latency expectations follow MULDIV_EARLY_OUT_EN).
module tb_muldiv_sequencer;
  localparam int unsigned XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EarlyLat  = 1;
  localparam int EarlyBusy = 0;
`else
  localparam int EarlyLat  = 33;
  localparam int EarlyBusy = 32;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Called #1 after an edge; returns #1 after the edge where done is seen.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cnt,
                        output bit timeout);
    int n;
    n = 0;
    while (!bus.ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    bus.Funct3 = f3;
    bus.src_a  = a;
    bus.src_b  = b;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_cnt  = 0;
    n         = 0;
    while (!bus.done && n < 100) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1; n++;
    end
    timeout = !bus.done;
    lat     = n + 1;
    res     = bus.result;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (bus.ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.ready);
                else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
                else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
                else n_pass++;
    n_checks++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h want 0", bus.result);
                else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int lat, bc;
    bit to;
    run_op(3'b000, 32'h7, 32'hFFFF_FFFD, r, lat, bc, to);
    n_checks++; if (to || r !== 32'hFFFF_FFEB) $display("FAIL mul_7x-3: got %h want ffffffeb", r);
                else n_pass++;
    n_checks++; if (lat !== 33) $display("FAIL mul_latency: got %0d want 33", lat);
                else n_pass++;
    n_checks++; if (bc !== 32) $display("FAIL mul_busy_cycles: got %0d want 32", bc);
                else n_pass++;
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, to);
    n_checks++; if (to || r !== 32'hFFFF_FFFE) $display("FAIL mulhu: got %h want fffffffe", r);
                else n_pass++;
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, to);
    n_checks++; if (to || r !== 32'h0) $display("FAIL mulh: got %h want 00000000", r);
                else n_pass++;
    run_op(3'b010, 32'hFFFF_FFFF, 32'h2, r, lat, bc, to);
    n_checks++; if (to || r !== 32'hFFFF_FFFF) $display("FAIL mulhsu: got %h want ffffffff", r);
                else n_pass++;
  endtask

  task automatic test_div();
    logic [31:0] r;
    int lat, bc;
    bit to;
    run_op(3'b100, 32'hFFFF_FFF9, 32'h2, r, lat, bc, to);
    n_checks++; if (to || r !== 32'hFFFF_FFFD) $display("FAIL div_-7/2: got %h want fffffffd", r);
                else n_pass++;
    run_op(3'b110, 32'hFFFF_FFF9, 32'h2, r, lat, bc, to);
    n_checks++; if (to || r !== 32'hFFFF_FFFF) $display("FAIL rem_-7/2: got %h want ffffffff", r);
                else n_pass++;
    run_op(3'b101, 32'd100, 32'd7, r, lat, bc, to);
    n_checks++; if (to || r !== 32'd14) $display("FAIL divu_100/7: got %h want 0000000e", r);
                else n_pass++;
    run_op(3'b111, 32'd100, 32'd7, r, lat, bc, to);
    n_checks++; if (to || r !== 32'd2) $display("FAIL remu_100/7: got %h want 00000002", r);
                else n_pass++;
  endtask

  task automatic test_special();
    logic [31:0] r;
    int lat, bc;
    bit to;
    run_op(3'b101, 32'd5, 32'd0, r, lat, bc, to);
    n_checks++; if (to || r !== 32'hFFFF_FFFF) $display("FAIL divu_by0: got %h want ffffffff", r);
                else n_pass++;
    n_checks++; if (lat !== EarlyLat) $display("FAIL divu_by0_lat: got %0d want %0d", lat, EarlyLat);
                else n_pass++;
    n_checks++; if (bc !== EarlyBusy) $display("FAIL divu_by0_busy: got %0d want %0d", bc, EarlyBusy);
                else n_pass++;
    run_op(3'b110, 32'd5, 32'd0, r, lat, bc, to);
    n_checks++; if (to || r !== 32'd5) $display("FAIL rem_by0: got %h want 00000005", r);
                else n_pass++;
    run_op(3'b100, 32'hFFFF_FFFB, 32'd0, r, lat, bc, to);
    n_checks++; if (to || r !== 32'hFFFF_FFFF) $display("FAIL div_neg_by0: got %h want ffffffff", r);
                else n_pass++;
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc, to);
    n_checks++; if (to || r !== 32'h8000_0000) $display("FAIL div_ovf: got %h want 80000000", r);
                else n_pass++;
    n_checks++; if (lat !== EarlyLat) $display("FAIL div_ovf_lat: got %0d want %0d", lat, EarlyLat);
                else n_pass++;
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc, to);
    n_checks++; if (to || r !== 32'h0) $display("FAIL rem_ovf: got %h want 00000000", r);
                else n_pass++;
    run_op(3'b000, 32'h0, 32'h1234_5678, r, lat, bc, to);
    n_checks++; if (to || r !== 32'h0) $display("FAIL mul_zero: got %h want 00000000", r);
                else n_pass++;
    n_checks++; if (lat !== EarlyLat) $display("FAIL mul_zero_lat: got %0d want %0d", lat, EarlyLat);
                else n_pass++;
  endtask

  task automatic test_flush();
    logic [31:0] r0, r;
    int lat, bc, dones;
    bit to;
    run_op(3'b000, 32'h7, 32'hFFFF_FFFD, r0, lat, bc, to);
    @(posedge clk); #1;
    bus.Funct3 = 3'b101; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL flush_pre_busy: got %b want 1", bus.busy);
                else n_pass++;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_checks++; if (bus.ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", bus.ready);
                else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", bus.busy);
                else n_pass++;
    n_checks++; if (bus.result !== 32'hFFFF_FFEB)
                  $display("FAIL flush_result_kept: got %h want ffffffeb", bus.result);
                else n_pass++;
    dones = 0;
    repeat (40) begin
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    n_checks++; if (dones !== 0) $display("FAIL flush_no_done: got %0d pulses want 0", dones);
                else n_pass++;
    run_op(3'b101, 32'd100, 32'd7, r, lat, bc, to);
    n_checks++; if (to || r !== 32'd14) $display("FAIL post_flush_divu: got %h want 0000000e", r);
                else n_pass++;
    n_checks++; if (lat !== 33) $display("FAIL post_flush_lat: got %0d want 33", lat);
                else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.Funct3 = 3'b111; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (bus.ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", bus.ready);
                else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy);
                else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", bus.done);
                else n_pass++;
    n_checks++; if (bus.result !== 32'h0) $display("FAIL rstmid_result: got %h want 0", bus.result);
                else n_pass++;
  endtask

  task automatic test_start_in_done();
    logic [31:0] r;
    int lat, bc, act;
    bit to;
    run_op(3'b000, 32'h7, 32'hFFFF_FFFD, r, lat, bc, to);
    bus.Funct3 = 3'b101; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++; if (bus.ready !== 1'b1) $display("FAIL done_start_ready: got %b want 1", bus.ready);
                else n_pass++;
    act = 0;
    repeat (5) begin
      if (bus.busy || bus.done) act++;
      @(posedge clk); #1;
    end
    n_checks++; if (act !== 0) $display("FAIL done_start_ignored: got %0d active cycles want 0", act);
                else n_pass++;
    n_checks++; if (bus.result !== 32'hFFFF_FFEB)
                  $display("FAIL done_start_result: got %h want ffffffeb", bus.result);
                else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int lat, bc;
    bit to;
    time t1, t2;
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, to);
    t1 = $time;
    run_op(3'b111, 32'd100, 32'd7, r, lat, bc, to);
    t2 = $time;
    n_checks++; if (to || r !== 32'd2) $display("FAIL b2b_remu: got %h want 00000002", r);
                else n_pass++;
    n_checks++; if ((t2 - t1) / 10 !== 34)
                  $display("FAIL b2b_period: got %0d cycles want 34", (t2 - t1) / 10);
                else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.Funct3 = 3'b000;
    bus.src_a  = '0;
    bus.src_b  = '0;
    reset      = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_start_in_done();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
